// File: rtl/sw_query_stream_if.sv
// Query-stream bundle for the Smith-Waterman receiver: host word input,
// job descriptor to the scheduler, and per-base output to the array loader.
interface sw_query_stream_if;
  logic         si_valid;
  logic         si_rdy;
  logic [127:0] si_data;

  logic         desc_valid;
  logic         desc_ready;
  logic [15:0]  desc_query_id;
  logic [31:0]  desc_ref_addr;
  logic [15:0]  desc_query_len;
  logic [31:0]  desc_ref_len;

  logic         base_valid;
  logic         base_ready;
  logic [1:0]   base_data;
  logic         base_last;

  // Host / scheduler / loader side.
  modport master (
    output si_valid, si_data, desc_ready, base_ready,
    input  si_rdy, desc_valid, desc_query_id, desc_ref_addr, desc_query_len,
           desc_ref_len, base_valid, base_data, base_last
  );

  // Receiver side.
  modport slave (
    input  si_valid, si_data, desc_ready, base_ready,
    output si_rdy, desc_valid, desc_query_id, desc_ref_addr, desc_query_len,
           desc_ref_len, base_valid, base_data, base_last
  );
endinterface

// File: rtl/sw_query_stream_rx.sv
// Receiver for the host-to-card query stream: parses a 128-bit header, issues a
// job descriptor, then unpacks 2-bit query bases LSB-first, one per cycle.
module sw_query_stream_rx #(
  parameter int MAX_QUERY_LEN = 256
) (
  input  logic                clk,
  input  logic                rst,
  sw_query_stream_if.slave    s,
  output logic                err,
  output logic                busy
);

  typedef enum logic [2:0] {
    HDR      = 3'd0,
    DESC     = 3'd1,
    SEQ_WAIT = 3'd2,
    EMIT     = 3'd3,
    DISCARD  = 3'd4
  } state_e;

  state_e        state_q,      state_d;
  logic          si_rdy_q,     si_rdy_d;
  logic          desc_valid_q, desc_valid_d;
  logic          base_valid_q, base_valid_d;
  logic          base_last_q,  base_last_d;
  logic          busy_q,       busy_d;
  logic          err_q,        err_d;
  logic [15:0]   id_q,         id_d;
  logic [31:0]   addr_q,       addr_d;
  logic [15:0]   qlen_q,       qlen_d;
  logic [31:0]   rlen_q,       rlen_d;
  logic [10:0]   words_left_q, words_left_d;
  logic [127:0]  shift_q,      shift_d;
  logic [15:0]   bases_sent_q, bases_sent_d;

  logic          si_hs;
  logic          base_hs;
  logic [15:0]   hdr_qlen;

  assign si_hs    = s.si_valid & si_rdy_q;
  assign base_hs  = base_valid_q & s.base_ready;
  assign hdr_qlen = s.si_data[79:64];

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d      = state_q;
    err_d        = err_q;
    id_d         = id_q;
    addr_d       = addr_q;
    qlen_d       = qlen_q;
    rlen_d       = rlen_q;
    words_left_d = words_left_q;
    shift_d      = shift_q;
    bases_sent_d = bases_sent_q;

    case (state_q)
      HDR: begin
        if (si_hs) begin
          id_d         = s.si_data[15:0];
          addr_d       = s.si_data[63:32];
          qlen_d       = hdr_qlen;
          rlen_d       = s.si_data[127:96];
          words_left_d = 11'((17'(hdr_qlen) + 17'd63) >> 6);
          bases_sent_d = '0;
          if (hdr_qlen == 16'd0) begin
            err_d = 1'b1;
          end else if (32'(hdr_qlen) > MAX_QUERY_LEN) begin
            err_d   = 1'b1;
            state_d = DISCARD;
          end else begin
            state_d = DESC;
          end
        end
      end
      DESC: begin
        if (desc_valid_q && s.desc_ready) state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (si_hs) begin
          shift_d      = s.si_data;
          words_left_d = words_left_q - 11'd1;
          state_d      = EMIT;
        end
      end
      EMIT: begin
        if (base_hs) begin
          shift_d      = shift_q >> 2;
          bases_sent_d = bases_sent_q + 16'd1;
          // Final base wins over the word boundary: tail bases of the last word are dropped.
          if (bases_sent_q == qlen_q - 16'd1) begin
            state_d = HDR;
          end else if (bases_sent_q[5:0] == 6'd63) begin
            state_d = SEQ_WAIT;
          end
        end
      end
      DISCARD: begin
        if (si_hs) begin
          words_left_d = words_left_q - 11'd1;
          if (words_left_q == 11'd1) state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase

    // Handshake outputs are registered copies of what the next state implies.
    si_rdy_d     = (state_d == HDR) || (state_d == SEQ_WAIT) || (state_d == DISCARD);
    desc_valid_d = (state_d == DESC);
    base_valid_d = (state_d == EMIT);
    base_last_d  = (state_d == EMIT) && (bases_sent_d == qlen_d - 16'd1);
    busy_d       = (state_d != HDR);
  end

  // NOTE: the shift register is ordinary flops, not a RAM, so clearing it on reset is cheap and keeps base_data at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HDR;
      si_rdy_q     <= 1'b0;
      desc_valid_q <= 1'b0;
      base_valid_q <= 1'b0;
      base_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      qlen_q       <= '0;
      rlen_q       <= '0;
      words_left_q <= '0;
      shift_q      <= '0;
      bases_sent_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      si_rdy_q     <= si_rdy_d;
      desc_valid_q <= desc_valid_d;
      base_valid_q <= base_valid_d;
      base_last_q  <= base_last_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      qlen_q       <= qlen_d;
      rlen_q       <= rlen_d;
      words_left_q <= words_left_d;
      shift_q      <= shift_d;
      bases_sent_q <= bases_sent_d;
    end
  end

  assign s.si_rdy         = si_rdy_q;
  assign s.desc_valid     = desc_valid_q;
  assign s.desc_query_id  = id_q;
  assign s.desc_ref_addr  = addr_q;
  assign s.desc_query_len = qlen_q;
  assign s.desc_ref_len   = rlen_q;
  assign s.base_valid     = base_valid_q;
  assign s.base_data      = shift_q[1:0];
  assign s.base_last      = base_last_q;
  assign err              = err_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_sw_query_stream_rx.sv
// Randomized scoreboard bench for sw_query_stream_rx: the driver pushes expected
// descriptors and bases, an independent negedge monitor pops and compares.
module tb_sw_query_stream_rx;
  localparam int MAX_LEN = 256;

  logic clk = 1'b0;
  logic rst;
  logic err, busy;

  sw_query_stream_if bus();

  sw_query_stream_rx #(.MAX_QUERY_LEN(MAX_LEN)) dut (
    .clk  (clk),
    .rst  (rst),
    .s    (bus.slave),
    .err  (err),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] id;
    logic [31:0] addr;
    logic [15:0] qlen;
    logic [31:0] rlen;
  } desc_t;

  typedef struct {
    logic [1:0] data;
    logic       last;
  } base_t;

  desc_t desc_q[$];
  base_t base_q[$];

  int   n_cmp = 0;
  int   n_fail = 0;
  int   base_hs_cnt = 0;
  int   last_cnt = 0;
  int   ready_mode = 0;
  int   desc_wait = 0;
  logic exp_err = 1'b0;

  logic       stall_pending = 1'b0;
  logic [1:0] held_data;
  logic       held_last;
  desc_t      md;
  base_t      mb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Ready generation: 0 = tied high, 1 = scripted backpressure, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        if (bus.desc_valid) desc_wait++;
        else desc_wait = 0;
        bus.desc_ready = (desc_wait > 5);
        bus.base_ready = ~bus.base_ready;
      end
      2: begin
        bus.desc_ready = ($urandom_range(0, 3) != 0);
        bus.base_ready = ($urandom_range(0, 3) != 0);
      end
      default: begin
        bus.desc_ready = 1'b1;
        bus.base_ready = 1'b1;
      end
    endcase
  end

  // Monitor: a valid&ready seen at negedge is the handshake of the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("base_hold_valid", 64'(bus.base_valid), 64'd1);
        check("base_hold_data",  64'(bus.base_data),  64'(held_data));
        check("base_hold_last",  64'(bus.base_last),  64'(held_last));
      end
      if (bus.desc_valid || bus.base_valid)
        check("si_rdy_low_while_busy", 64'(bus.si_rdy), 64'd0);
      if (bus.desc_valid && bus.desc_ready) begin
        if (desc_q.size() == 0) begin
          timeout("unexpected_desc");
        end else begin
          md = desc_q.pop_front();
          check("desc_query_id",  64'(bus.desc_query_id),  64'(md.id));
          check("desc_ref_addr",  64'(bus.desc_ref_addr),  64'(md.addr));
          check("desc_query_len", 64'(bus.desc_query_len), 64'(md.qlen));
          check("desc_ref_len",   64'(bus.desc_ref_len),   64'(md.rlen));
        end
      end
      if (bus.base_valid && bus.base_ready) begin
        if (base_q.size() == 0) begin
          timeout("unexpected_base");
        end else begin
          mb = base_q.pop_front();
          check("base_data", 64'(bus.base_data), 64'(mb.data));
          check("base_last", 64'(bus.base_last), 64'(mb.last));
        end
        base_hs_cnt++;
        if (bus.base_last) last_cnt++;
      end
      stall_pending = bus.base_valid && !bus.base_ready;
      held_data     = bus.base_data;
      held_last     = bus.base_last;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [127:0] d, output int waits);
    waits = 0;
    bus.si_valid = 1'b1;
    bus.si_data  = d;
    forever begin
      @(negedge clk);
      if (bus.si_rdy) break;
      waits++;
      if (waits > 4000) begin
        timeout("send_word");
        bus.si_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    bus.si_valid = 1'b0;
    bus.si_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference model: a query of qlen bases occupies ceil(qlen/64) words, base k
  // sits at bits [2k+1:2k] of word k/64; bad lengths raise err and emit nothing.
  task automatic run_job(input logic [15:0] id, input logic [31:0] addr,
                         input logic [15:0] qlen, input logic [31:0] rlen,
                         input logic use_fixed, input logic [127:0] fixed_word,
                         output int hdr_waits);
    logic [127:0] hdr;
    logic [127:0] word;
    int           nwords;
    int           idx;
    int           wt;
    logic         good;
    hdr    = {rlen, 16'($urandom), qlen, addr, 16'($urandom), id};
    nwords = (int'(qlen) + 63) / 64;
    good   = (qlen != 16'd0) && (int'(qlen) <= MAX_LEN);
    if (!good) exp_err = 1'b1;
    else desc_q.push_back('{id, addr, qlen, rlen});
    send_word(hdr, hdr_waits);
    if (good) check("hdr_to_desc_valid", 64'(bus.desc_valid), 64'd1);
    for (int w = 0; w < nwords; w++) begin
      word = use_fixed ? fixed_word : {$urandom, $urandom, $urandom, $urandom};
      if (good) begin
        for (int k = 0; k < 64; k++) begin
          idx = w * 64 + k;
          if (idx < int'(qlen))
            base_q.push_back('{word[2*k +: 2], (idx == int'(qlen) - 1)});
        end
      end
      send_word(word, wt);
      if (good) check("word_to_base_valid", 64'(bus.base_valid), 64'd1);
    end
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (desc_q.size() != 0 || base_q.size() != 0) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt > 5000) begin
        timeout("drain");
        desc_q.delete();
        base_q.delete();
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("err_flag",  64'(err),  64'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_desc_valid"}, 64'(bus.desc_valid), 64'd0);
    check({tag, "_base_valid"}, 64'(bus.base_valid), 64'd0);
    check({tag, "_base_data"},  64'(bus.base_data),  64'd0);
    check({tag, "_base_last"},  64'(bus.base_last),  64'd0);
    check({tag, "_si_rdy"},     64'(bus.si_rdy),     64'd0);
    check({tag, "_busy"},       64'(busy),           64'd0);
    check({tag, "_err"},        64'(err),            64'd0);
    check({tag, "_qlen"},       64'(bus.desc_query_len), 64'd0);
  endtask

  localparam logic [127:0] NOM_WORD = 128'hc8facaa7c280aa28a020aaaf89aae004;

  initial begin
    int hw;
    int cnt;
    int start;
    int lc;
    logic [15:0] rl;

    rst = 1'b1;
    bus.si_valid   = 1'b0;
    bus.si_data    = '0;
    bus.desc_ready = 1'b0;
    bus.base_ready = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal job.
    ready_mode = 0;
    run_job(16'd8, 32'd0, 16'd64, 32'd128, 1'b1, NOM_WORD, hw);
    wait_idle();

    // Same job under backpressure.
    ready_mode = 1;
    run_job(16'd8, 32'd0, 16'd64, 32'd128, 1'b1, NOM_WORD, hw);
    wait_idle();

    // Two-word odd length.
    ready_mode = 0;
    run_job(16'h0101, 32'h1000_0000, 16'd100, 32'd5000, 1'b0, '0, hw);
    wait_idle();

    // Zero length, then a valid job.
    run_job(16'h0202, 32'h0, 16'd0, 32'd1, 1'b0, '0, hw);
    wait_idle();
    run_job(16'h0203, 32'h40, 16'd37, 32'd77, 1'b0, '0, hw);
    wait_idle();

    // Oversize: five words consumed and dropped, then a valid job.
    run_job(16'h0300, 32'h80, 16'd300, 32'd9, 1'b0, '0, hw);
    wait_idle();
    ready_mode = 2;
    run_job(16'h0301, 32'hC0, 16'd128, 32'd999, 1'b0, '0, hw);
    wait_idle();

    // Reset after ten bases of a job.
    ready_mode = 0;
    run_job(16'h0400, 32'h100, 16'd64, 32'd64, 1'b0, '0, hw);
    start = base_hs_cnt;
    cnt = 0;
    while (base_hs_cnt < start + 10 && cnt < 200) begin
      @(posedge clk);
      cnt++;
    end
    if (cnt >= 200) timeout("reset_wait_bases");
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    desc_q.delete();
    base_q.delete();
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_job(16'h0401, 32'h200, 16'd65, 32'd300, 1'b0, '0, hw);
    wait_idle();

    // Back-to-back: second header right after the first base_last handshake.
    run_job(16'h0500, 32'h300, 16'd20, 32'd40, 1'b0, '0, hw);
    lc = last_cnt;
    cnt = 0;
    while (last_cnt == lc && cnt < 500) begin
      @(posedge clk);
      cnt++;
    end
    if (cnt >= 500) timeout("b2b_wait_last");
    #1;
    check("b2b_desc_held", 64'(bus.desc_query_id), 64'h0500);
    run_job(16'h0501, 32'h400, 16'd70, 32'd80, 1'b0, '0, hw);
    check("b2b_hdr_wait", 64'(hw), 64'd0);
    wait_idle();

    // Random jobs with random backpressure, including occasional bad lengths.
    ready_mode = 2;
    for (int j = 0; j < 14; j++) begin
      case ($urandom_range(0, 7))
        0:       rl = 16'd0;
        1:       rl = 16'($urandom_range(MAX_LEN + 1, 400));
        2:       rl = 16'(MAX_LEN);
        default: rl = 16'($urandom_range(1, MAX_LEN));
      endcase
      run_job(16'($urandom), $urandom, rl, $urandom, 1'b0, '0, hw);
      wait_idle();
    end

    check("final_desc_queue", 64'(desc_q.size()), 64'd0);
    check("final_base_queue", 64'(base_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
